// File: rtl/score_display_pkg.sv
// Shared constants, types and helpers for the score display slice.
package score_display_pkg;

    // Score counter MSB index; the score bus is SCORELEN+1 bits wide.
    localparam int SCORELEN = 13;

    // Segment codes, bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_e;

    // 10^n, used to derive the saturation threshold from the digit count.
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // BCD nibble to segment pattern; non-decimal codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble converter: re-converts the score whenever it
// differs from the last converted value, saturating at all nines.
module bin2bcd_seq
    import score_display_pkg::*;
#(
    parameter int SCORE_W = SCORELEN + 1,
    parameter int DIGITS  = 4
) (
    input  logic                  clk3,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    score,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  ovf
);

    localparam int BCD_W     = 4 * DIGITS;
    localparam int CNT_W     = $clog2(SCORE_W + 1);
    localparam int SAT_LIMIT = pow10(DIGITS);

    conv_state_e          state_q;
    logic [SCORE_W-1:0]   last_q;
    logic [SCORE_W-1:0]   shreg_q;
    logic [BCD_W-1:0]     acc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BCD_W-1:0]     bcd_q;
    logic                 bcd_valid_q;
    logic                 ovf_q;

    logic [BCD_W-1:0]     adj_s;
    logic [BCD_W-1:0]     new_acc_s;
    logic [SCORE_W-1:0]   new_shreg_s;
    logic                 sat_s;

    // Values that cannot be shown in DIGITS decimal digits skip conversion.
    assign sat_s = (32'(score) >= 32'(SAT_LIMIT));

    // Add-3 correction on every nibble of 5 or more, then the one-bit shift.
    always_comb begin
        adj_s = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                adj_s[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end else begin
                adj_s[4*i +: 4] = acc_q[4*i +: 4];
            end
        end
        new_acc_s   = {adj_s[BCD_W-2:0], shreg_q[SCORE_W-1]};
        new_shreg_s = {shreg_q[SCORE_W-2:0], 1'b0};
    end

    // IDLE/CONV conversion FSM with registered bcd, bcd_valid and ovf.
    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= '0;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            bcd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (score != last_q) begin
                        last_q <= score;
                        if (sat_s) begin
                            bcd_q       <= {DIGITS{4'h9}};
                            ovf_q       <= 1'b1;
                            bcd_valid_q <= 1'b1;
                        end else begin
                            shreg_q <= score;
                            acc_q   <= '0;
                            cnt_q   <= CNT_W'(SCORE_W);
                            state_q <= ST_CONV;
                        end
                    end
                end
                ST_CONV: begin
                    acc_q   <= new_acc_s;
                    shreg_q <= new_shreg_s;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        bcd_q       <= new_acc_s;
                        bcd_valid_q <= 1'b1;
                        ovf_q       <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: rtl/score_display.sv
// Multiplexed 7-segment score display: digit scan, leading-zero blanking,
// pause blink and segment decode around the sequential BCD converter.
module score_display
    import score_display_pkg::*;
#(
    parameter int SCORE_W   = SCORELEN + 1,
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic                  clk3,
    input  logic                  reset,
    input  logic [SCORE_W-1:0]    score,
    input  logic                  pause,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  ovf
);

    localparam int PRE_W = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int IDX_W = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PRE_W-1:0]     presc_q, presc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BLK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                 phase_q, phase_d;

    logic                 wrap_s;
    logic [4*DIGITS-1:0]  bcd_s;
    logic [4*DIGITS-1:0]  shifted_s;
    logic                 upper_zero_s;
    logic [6:0]           seg_s;
    logic [DIGITS-1:0]    an_s;

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk3      (clk3),
        .reset     (reset),
        .score     (score),
        .bcd       (bcd_s),
        .bcd_valid (bcd_valid),
        .ovf       (ovf)
    );

    assign wrap_s = (presc_q == PRE_W'(SCAN_DIV - 1));

    // Prescaler and digit index: one scan step every SCAN_DIV cycles.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        if (wrap_s) begin
            presc_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            presc_d = presc_q + PRE_W'(1);
            idx_d   = idx_q;
        end
    end

    // Blink phase: toggles every BLINK_DIV scan steps while paused.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (!pause) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (wrap_s) begin
            if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
                phase_d     = phase_q;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
            phase_d     = phase_q;
        end
    end

    // Scan and blink state registers.
    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // One-hot digit enable from the scan index.
    always_comb begin
        an_s = '0;
        for (int i = 0; i < DIGITS; i++) begin
            an_s[i] = (idx_q == IDX_W'(i));
        end
    end

    // Selected nibble decode; blank during the off phase and for leading zeros.
    always_comb begin
        shifted_s    = bcd_s >> {idx_q, 2'b00};
        upper_zero_s = (shifted_s == '0);
        if (phase_q) begin
            seg_s = SEG_BLANK;
        end else if ((idx_q != '0) && upper_zero_s) begin
            seg_s = SEG_BLANK;
        end else begin
            seg_s = seg_decode(shifted_s[3:0]);
        end
    end

    assign seg = seg_s;
    assign an  = an_s;
    assign bcd = bcd_s;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: directed scenarios with literal expectations plus
// randomized score/pause/reset traffic checked every cycle against a model.
module tb_score_display;

    localparam int SCORE_W   = 14;
    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 2;

    logic                clk3  = 1'b0;
    logic                reset = 1'b0;
    logic                pause = 1'b0;
    logic [SCORE_W-1:0]  score = '0;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an;
    logic [15:0]         bcd;
    logic                bcd_valid;
    logic                ovf;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    score_display #(
        .SCORE_W   (SCORE_W),
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk3      (clk3),
        .reset     (reset),
        .score     (score),
        .pause     (pause),
        .seg       (seg),
        .an        (an),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .ovf       (ovf)
    );

    always #5 clk3 = ~clk3;

    // ---------------- behavioural model ----------------
    // Displayed value as a plain integer, conversion as an edge countdown,
    // scan position and blink phase derived from cycle/step counts.
    int m_cyc, m_steps, m_busy, m_val, m_pend, m_last;
    bit m_valid, m_ovf;

    always @(posedge clk3 or posedge reset) begin
        if (reset) begin
            m_cyc   <= 0;
            m_steps <= 0;
            m_busy  <= 0;
            m_val   <= 0;
            m_pend  <= 0;
            m_last  <= 0;
            m_valid <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!pause) m_steps <= 0;
            else if (m_cyc % SCAN_DIV == SCAN_DIV - 1) m_steps <= m_steps + 1;
            m_valid <= 1'b0;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_val   <= m_pend;
                    m_ovf   <= 1'b0;
                    m_valid <= 1'b1;
                end
            end else if (int'(score) != m_last) begin
                m_last <= int'(score);
                if (int'(score) >= 10000) begin
                    m_val   <= 9999;
                    m_ovf   <= 1'b1;
                    m_valid <= 1'b1;
                end else begin
                    m_pend <= int'(score);
                    m_busy <= SCORE_W;
                end
            end
        end
    end

    function automatic int p10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] exp_bcd_f(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
        return r;
    endfunction

    function automatic logic [6:0] exp_seg_f();
        int idx;
        int d;
        idx = (m_cyc / SCAN_DIV) % DIGITS;
        if ((m_steps / BLINK_DIV) % 2 == 1) return 7'h00;
        if (idx > 0 && m_val < p10(idx)) return 7'h00;
        d = (m_val / p10(idx)) % 10;
        return seg_tab[d];
    endfunction

    function automatic logic [3:0] exp_an_f();
        int idx;
        idx = (m_cyc / SCAN_DIV) % DIGITS;
        return 4'(1 << idx);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk3) begin
        if (cmp_en) begin
            chk("an",        32'(an),        32'(exp_an_f()));
            chk("seg",       32'(seg),       32'(exp_seg_f()));
            chk("bcd",       32'(bcd),       32'(exp_bcd_f(m_val)));
            chk("bcd_valid", 32'(bcd_valid), 32'(m_valid));
            chk("ovf",       32'(ovf),       32'(m_ovf));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_score(input int v);
        @(posedge clk3);
        #1 score = SCORE_W'(v);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 60) begin
            @(posedge clk3);
            n++;
            @(negedge clk3);
            if (bcd_valid === 1'b1) break;
        end
    endtask

    // ev = {d3,d2,d1,d0} segment expectations over one full scan.
    task automatic scan_lit(input logic [27:0] ev);
        repeat (16) begin
            @(negedge clk3);
            for (int i = 0; i < 4; i++) begin
                if (an == 4'(1 << i)) chk($sformatf("scan_d%0d", i), 32'(seg), 32'(ev[7*i +: 7]));
            end
        end
    endtask

    function automatic int pick_score();
        int k;
        k = $urandom_range(0, 3);
        case (k)
            0:       return $urandom_range(0, 9);
            1:       return $urandom_range(0, 999);
            2:       return $urandom_range(0, 9999);
            default: return $urandom_range(10000, 16383);
        endcase
    endfunction

    int n;
    int pulses;
    int blanks, lits, moves;
    logic [3:0] prev_an;

    initial begin
        // Reset with score 0.
        reset = 1'b1;
        repeat (3) @(posedge clk3);
        #1 reset = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk3);
        chk("reset_an",  32'(an),  32'h1);
        chk("reset_seg", 32'(seg), 32'h3F);
        pulses = 0;
        repeat (16) begin
            @(negedge clk3);
            if (bcd_valid === 1'b1) pulses++;
        end
        chk("no_pulse_at_0", 32'(pulses), 32'd0);
        scan_lit({7'h00, 7'h00, 7'h00, 7'h3F});

        // 1234: latency, value, per-digit segments.
        drive_score(1234);
        wait_valid(n);
        chk("lat_1234", 32'(n), 32'd15);
        chk("bcd_1234", 32'(bcd), 32'h1234);
        chk("ovf_1234", 32'(ovf), 32'd0);
        scan_lit({7'h06, 7'h5B, 7'h4F, 7'h66});

        // 50: leading-zero blanking.
        drive_score(50);
        wait_valid(n);
        chk("bcd_0050", 32'(bcd), 32'h0050);
        scan_lit({7'h00, 7'h00, 7'h6D, 7'h3F});

        // 7 then 8 arriving mid-conversion.
        drive_score(7);
        n = 0;
        while (n < 60) begin
            @(posedge clk3);
            n++;
            if (n == 6) #1 score = SCORE_W'(8);
            @(negedge clk3);
            if (bcd_valid === 1'b1) break;
        end
        chk("lat_7", 32'(n), 32'd15);
        chk("bcd_7", 32'(bcd), 32'h0007);
        wait_valid(n);
        chk("lat_8", 32'(n), 32'd15);
        chk("bcd_8", 32'(bcd), 32'h0008);

        // Saturation and recovery.
        drive_score(12000);
        wait_valid(n);
        chk("lat_sat", 32'(n), 32'd1);
        chk("bcd_sat", 32'(bcd), 32'h9999);
        chk("ovf_sat", 32'(ovf), 32'd1);
        drive_score(42);
        wait_valid(n);
        chk("lat_42", 32'(n), 32'd15);
        chk("bcd_42", 32'(bcd), 32'h0042);
        chk("ovf_42", 32'(ovf), 32'd0);

        // Blink while paused on an all-lit value.
        drive_score(8888);
        wait_valid(n);
        chk("bcd_8888", 32'(bcd), 32'h8888);
        @(posedge clk3);
        #1 pause = 1'b1;
        blanks = 0;
        lits   = 0;
        moves  = 0;
        prev_an = an;
        repeat (40) begin
            @(negedge clk3);
            if (seg == 7'h00) blanks++;
            else if (seg == 7'h7F) lits++;
            if (an != prev_an) moves++;
            prev_an = an;
        end
        chk("blink_off_seen", 32'(blanks >= 12), 32'd1);
        chk("blink_on_seen",  32'(lits >= 12),   32'd1);
        chk("scan_in_pause",  32'(moves >= 9),   32'd1);
        @(posedge clk3);
        #1 pause = 1'b0;

        // Reset in the middle of a conversion.
        drive_score(999);
        repeat (5) @(posedge clk3);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_an",  32'(an),  32'h1);
        chk("rst_mid_seg", 32'(seg), 32'h3F);
        chk("rst_mid_bcd", 32'(bcd), 32'h0);
        repeat (2) @(posedge clk3);
        #1 reset = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk3);
            #1;
            reset = 1'b0;
            if ($urandom_range(0, 99) < 6) score = SCORE_W'(pick_score());
            if ($urandom_range(0, 99) < 2) pause = ~pause;
            if ($urandom_range(0, 599) == 0) reset = 1'b1;
        end
        @(posedge clk3);
        #1;
        reset = 1'b0;
        pause = 1'b0;
        repeat (20) @(posedge clk3);
        @(negedge clk3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
